// File: rtl/llander_input_pkg.sv
// Shared types and constants for the lunar-lander input conditioning path.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
package llander_input_pkg;

  typedef logic [7:0] thrust_t;

  // The board DAC never produced 0xFF, so every thrust source stops one short.
  localparam int THRUST_MAX_DEFAULT = 254;

  typedef enum logic {
    TURN_IDLE   = 1'b0,
    TURN_ACTIVE = 1'b1
  } turn_state_t;

  // Clamp a 9-bit signed thrust target into [0, max_v].
  function automatic thrust_t clamp_thrust(input logic signed [8:0] v,
                                           input thrust_t           max_v);
    thrust_t r;
    if (v < 9'sd0) begin
      r = '0;
    end else if (v > $signed({1'b0, max_v})) begin
      r = max_v;
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/thrust_conditioner_tick_divider.sv
// Free-running divider producing a one-cycle pulse every DIV cycles.
// Latency: pulse is high while the count sits at DIV-1; first pulse DIV cycles after reset release.
// Backpressure: none; never stalls and is never cleared except by reset.
//
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset
//   tick_o  - one-cycle pulse, high while count == DIV-1
module tick_divider #(
  parameter int DIV = 98425
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/thrust_conditioner.sv
// Converts raw stick axes and thrust buttons into THRUST and active-low turn requests.
// Latency: analog/turn 2 cycles input-to-output; d-pad thrust 1 cycle after the ramp tick.
// Backpressure: none; inputs are sampled every cycle and outputs are always valid.
//
// Ports:
//   clk_25    - system clock (shared with hps_io)
//   RESET_L   - asynchronous active-low reset
//   mode_dpad - thrust source: 1 = d-pad accumulator, 0 = analog stick Y
//   analog_x  - signed stick X, negative = left
//   analog_y  - signed stick Y, negative = up = more thrust
//   thr_up    - thrust increase button (already ORed with keyboard)
//   thr_dn    - thrust decrease button
//   thrust    - unsigned thrust to LLANDER_TOP.THRUST
//   turn_l_n  - active-low left turn request
//   turn_r_n  - active-low right turn request
//
// Optional feature macro THRUST_SLEW_EN: rate-limits the analog path through a
// slew register stepping one LSB every SLEW_DIV cycles.
module thrust_conditioner
  import llander_input_pkg::*;
#(
  parameter int TICK_DIV   = 98425,
  parameter int THRUST_MAX = THRUST_MAX_DEFAULT,
  parameter int TURN_ON    = 64,
  parameter int TURN_OFF   = 48,
  parameter int SLEW_DIV   = 1024
) (
  input  logic       clk_25,
  input  logic       RESET_L,
  input  logic       mode_dpad,
  input  logic [7:0] analog_x,
  input  logic [7:0] analog_y,
  input  logic       thr_up,
  input  logic       thr_dn,
  output thrust_t    thrust,
  output logic       turn_l_n,
  output logic       turn_r_n
);

  localparam thrust_t THR_MAX = thrust_t'(THRUST_MAX);

  // Input capture
  logic signed [7:0] x_q;
  logic signed [7:0] y_q;
  logic              up_q;
  logic              dn_q;
  logic              mode_q;
  logic              mode_prev_q;

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      x_q         <= '0;
      y_q         <= '0;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
      mode_q      <= 1'b0;
      mode_prev_q <= 1'b0;
    end else begin
      x_q         <= analog_x;
      y_q         <= analog_y;
      up_q        <= thr_up;
      dn_q        <= thr_dn;
      mode_q      <= mode_dpad;
      mode_prev_q <= mode_q;
    end
  end

  logic mode_rise;
  logic mode_fall;
  assign mode_rise = mode_q & ~mode_prev_q;
  assign mode_fall = ~mode_q & mode_prev_q;

  // Analog target: stick up (negative Y) means more thrust.
  logic signed [8:0] tgt;
  thrust_t           tgt_clamped;

  always_comb begin
    tgt         = 9'sd127 - $signed({y_q[7], y_q});
    tgt_clamped = clamp_thrust(tgt, THR_MAX);
  end

  // Ramp tick
  logic tick;

  tick_divider #(
    .DIV (TICK_DIV)
  ) u_ramp_div (
    .clk_i  (clk_25),
    .rst_ni (RESET_L),
    .tick_o (tick)
  );

  // D-pad accumulator
  thrust_t acc_q;
  thrust_t acc_d;
  thrust_t thrust_q;
  thrust_t thrust_d;

  always_comb begin
    acc_d = acc_q;
    if (mode_rise) begin
      // Pick up from whatever the analog path was showing so the output does not jump.
      acc_d = thrust_q;
    end else if (mode_fall) begin
      acc_d = acc_q;
    end else if (tick) begin
      if (up_q && !dn_q) begin
        if (acc_q < THR_MAX) begin
          acc_d = acc_q + 8'd1;
        end
      end else if (dn_q && !up_q) begin
        if (acc_q != 8'd0) begin
          acc_d = acc_q - 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Analog source, optionally slew limited
  thrust_t analog_thr;

`ifdef THRUST_SLEW_EN
  logic    slew_tick;
  thrust_t slw_q;
  thrust_t slw_d;

  tick_divider #(
    .DIV (SLEW_DIV)
  ) u_slew_div (
    .clk_i  (clk_25),
    .rst_ni (RESET_L),
    .tick_o (slew_tick)
  );

  always_comb begin
    slw_d = slw_q;
    if (mode_q) begin
      // Shadow the accumulator so returning to analog starts from the current output.
      slw_d = acc_q;
    end else if (slew_tick) begin
      if (slw_q < tgt_clamped) begin
        slw_d = slw_q + 8'd1;
      end else if (slw_q > tgt_clamped) begin
        slw_d = slw_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      slw_q <= '0;
    end else begin
      slw_q <= slw_d;
    end
  end

  assign analog_thr = slw_q;
`else
  // SLEW_DIV only matters when the slew path is built.
  if (SLEW_DIV < 1) begin : g_slew_div_unused
  end

  assign analog_thr = tgt_clamped;
`endif

  // Output mux
  always_comb begin
    thrust_d = thrust_q;
    if (mode_rise) begin
      // acc is being loaded from thrust_q this cycle; hold so the switch is seamless.
      thrust_d = thrust_q;
    end else if (mode_q) begin
      thrust_d = acc_q;
    end else begin
      thrust_d = analog_thr;
    end
  end

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      thrust_q <= '0;
    end else begin
      thrust_q <= thrust_d;
    end
  end

  assign thrust = thrust_q;

  // Turn FSMs with hysteresis; thresholds are disjoint so both cannot be active.
  turn_state_t left_q;
  turn_state_t left_d;
  turn_state_t right_q;
  turn_state_t right_d;

  always_comb begin
    left_d  = left_q;
    right_d = right_q;

    case (left_q)
      TURN_IDLE:   if (int'(x_q) < -TURN_ON)  left_d = TURN_ACTIVE;
      TURN_ACTIVE: if (int'(x_q) > -TURN_OFF) left_d = TURN_IDLE;
      default:     left_d = TURN_IDLE;
    endcase

    case (right_q)
      TURN_IDLE:   if (int'(x_q) > TURN_ON)  right_d = TURN_ACTIVE;
      TURN_ACTIVE: if (int'(x_q) < TURN_OFF) right_d = TURN_IDLE;
      default:     right_d = TURN_IDLE;
    endcase
  end

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      left_q  <= TURN_IDLE;
      right_q <= TURN_IDLE;
    end else begin
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  assign turn_l_n = (left_q != TURN_ACTIVE);
  assign turn_r_n = (right_q != TURN_ACTIVE);

endmodule

// File: doc/thrust_conditioner.md
# thrust_conditioner

Input-conditioning stage sitting directly upstream of `LLANDER_TOP`. It converts the raw analog-stick axes and the d-pad/keyboard thrust-up/down buttons into the 8-bit `THRUST` value and the active-low `ROT_LEFT_L`/`ROT_RIGHT_L` turn inputs. It provides:
- a ramped d-pad thrust accumulator;
- analog thrust mapping with a hardware-safe clamp;
- turn thresholds with hysteresis;
- bumpless switching between the analog and d-pad thrust sources.

## Interface
Parameters:
- `TICK_DIV`, default 98425: clk_25 cycles per d-pad ramp step; 254 steps take about 1 s.
- `THRUST_MAX`, default 254: upper clamp for every thrust source, because the board DAC never produced 0xFF.
- `TURN_ON`, default 64: magnitude that the x axis must strictly exceed to assert a turn.
- `TURN_OFF`, default 48: magnitude that the x axis must fall strictly below to release a turn.
- `SLEW_DIV`, default 1024: cycles per analog slew step (only used with `THRUST_SLEW_EN`).

Ports (one clock; reset is asynchronous and active-low):
- `clk_25  in  1` — system clock, shared with hps_io.
- `RESET_L  in  1` — asynchronous, active-low reset.
- `mode_dpad  in  1` — thrust source select: 1 = d-pad, 0 = analog.
- `analog_x  in  8` — signed stick X; negative = left.
- `analog_y  in  8` — signed stick Y; negative = up, which means more thrust.
- `thr_up  in  1` — thrust-increase button, active-high, already ORed with the keyboard input.
- `thr_dn  in  1` — thrust-decrease button, active-high.
- `thrust  out  8` — unsigned thrust value to `LLANDER_TOP.THRUST`.
- `turn_l_n  out  1` — active-low stick-left turn request.
- `turn_r_n  out  1` — active-low stick-right turn request.

## Operation
Input registers:
- `analog_x`, `analog_y`, `thr_up`, `thr_dn` and `mode_dpad` are captured into `_q` registers every cycle.
- All logic below uses only the `_q` values.

Analog target:
- `tgt = 127 - y_q`, computed as a 9-bit signed value.
- `y = -128` gives 255, which is clamped to `THRUST_MAX` (254). `y = 127` gives 0.

Tick prescaler:
- The counter runs 0..`TICK_DIV-1` and wraps.
- `tick` is high for one cycle while the count equals `TICK_DIV-1`.
- The prescaler is free-running and is never cleared by button or mode activity.

D-pad accumulator `acc`:
- On `tick`, up only (`up_q & ~dn_q`): `acc` increments when `acc < THRUST_MAX`.
- On `tick`, down only: `acc` decrements when `acc > 0`.
- Up and down pressed together: no change.
- Without a tick, `acc` holds.

Mode-change handling:
- On the rising edge of `mode_q` (switch to d-pad), `acc` loads the current `thrust` so the output does not jump.
- This load takes priority over a coincident tick.
- On the falling edge of `mode_q`, `acc` holds its value.

Output mux:
- `thrust` is registered as `mode_q ? acc : clamp(tgt)` (or the slewed value, see Configuration).

Turn state, one independent two-state FSM per direction (IDLE/ACTIVE):
- Left, IDLE→ACTIVE when `x_q < -TURN_ON`.
- Left, ACTIVE→IDLE when `x_q > -TURN_OFF`.
- Right mirrors left: IDLE→ACTIVE when `x_q > TURN_ON`, ACTIVE→IDLE when `x_q < TURN_OFF`.
- Both directions can never be ACTIVE at the same time, because the thresholds are disjoint.
- `turn_l_n = ~left_active` and `turn_r_n = ~right_active`, both driven from registers.

## Timing
Reset values:
- `thrust` = 0.
- `acc` = 0.
- Prescaler = 0.
- All `_q` registers = 0.
- Turn FSMs in IDLE, so `turn_l_n` = `turn_r_n` = 1.
- Slew register (when present) = 0.

Latencies:
- Analog thrust: an input change at clock edge N appears on `thrust` at edge N+2.
- D-pad thrust: `acc` updates on the tick edge T; `thrust` reflects it at T+1.
- Turns: an `analog_x` change at edge N appears on `turn_*_n` at edge N+2.
- Mode change: `mode_dpad` toggling at edge N selects the new source at edge N+2.

Boundary behaviour:
- `acc` saturates at 0 and at `THRUST_MAX`; it never wraps.
- Reset asserted mid-ramp clears everything immediately, asynchronously.
- After `RESET_L` deasserts, the first tick occurs `TICK_DIV` cycles later.

## Configuration
Feature macro `THRUST_SLEW_EN`.

When defined:
- The analog path goes through a slew register `slw`.
- Every `SLEW_DIV` cycles, `slw` moves one LSB toward `clamp(tgt)`; it holds when equal.
- In analog mode, `thrust = slw`.
- While in d-pad mode, `slw` tracks `acc` each cycle, so switching back to analog is bumpless.

When not defined:
- The slew register and its divider are absent.
- Analog thrust follows `clamp(tgt)` with the 2-cycle latency given above.

## Structure
Shared package `llander_input_pkg`:
- `typedef logic [7:0] thrust_t`.
- The `THRUST_MAX_DEFAULT` constant.
- `typedef enum {TURN_IDLE, TURN_ACTIVE} turn_state_t`.

Sub-module `tick_divider`:
- A parameterised free-running divider with a one-cycle pulse output.
- Instantiated once for the ramp tick and, under `THRUST_SLEW_EN`, a second time for the slew tick.

## Test plan
- Reset, then `mode_dpad=1` with `thr_up` held for 254×`TICK_DIV` cycles → `thrust` steps 0→254 one LSB per tick and stays at 254 when held longer.
- `mode_dpad=0`: drive `analog_y = -128`, then 127, then 0 → `thrust` is 254, 0, 127, each change appearing 2 cycles after the input.
- `analog_x` sweeps -70 → -50 → -40 → `turn_l_n` goes to 0 at -70, stays 0 at -50, and returns to 1 at -40; `turn_r_n` stays 1 throughout.
- Analog at `y = -100` (thrust 227), then switch to `mode_dpad=1` → `thrust` stays at 227 with no glitch, and the next up-tick gives 228.
- `thr_up` and `thr_dn` held together over 5 ticks → `thrust` unchanged; `RESET_L` pulsed low mid-ramp → `thrust` is 0 immediately.
- With `THRUST_SLEW_EN` defined: `y` steps from 127 to -128 → `thrust` rises one LSB every `SLEW_DIV` cycles until it reaches 254.
